// File: rtl/mutex_arbiter_pkg.sv
// ============================================================================
// mutex_pkg : shared FSM state type and index-width helper for mutex_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mutex_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    HELD = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mutex_arbiter_if.sv
// ============================================================================
// mutex_arbiter_if : request/release/grant bundle between processes and lock
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mutex_arbiter_if
  import mutex_pkg::*;
#(
  parameter int N = 2,
  localparam int IDW = idx_w(N)
);

  // "release" is a reserved word, so the release pulses travel as rel
  logic [N-1:0]   req;
  logic [N-1:0]   rel;
  logic [N-1:0]   grant;
  logic           busy;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] turn;
  logic           timeout_err;

  modport master (
    output req, rel,
    input  grant, busy, owner, turn, timeout_err
  );

  modport slave (
    input  req, rel,
    output grant, busy, owner, turn, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/mutex_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first requester at or after turn
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_pick
  import mutex_pkg::*;
#(
  parameter int N = 2,
  localparam int IDW = idx_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] turn,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(turn) + k) % N]) begin
        valid = 1'b1;
        idx   = IDW'((int'(turn) + k) % N);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mutex_arbiter.sv
// ============================================================================
// mutex_arbiter : registered round-robin mutual-exclusion lock with timeout
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mutex_arbiter
  import mutex_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 0,
  localparam int IDW    = idx_w(N)
) (
  input  logic            clock,
  input  logic            reset,
  mutex_arbiter_if.slave  bus
);

  localparam logic [N-1:0] ONE_LSB = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           busy_q, busy_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] turn_q, turn_d;
  logic           terr_q, terr_d;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic           owner_done;
  logic           hold_expired;

  rr_pick #(.N(N)) u_rr_pick (
    .req   (bus.req),
    .turn  (turn_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Dropping the request counts the same as an explicit release.
  assign owner_done = bus.rel[owner_q] | ~bus.req[owner_q];

  generate
    if (TIMEOUT > 0) begin : g_hold_cnt
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (state_q == FREE)
          cnt_d = '0;
        else if (state_q == HELD && cnt_q != CW'(TIMEOUT))
          cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign hold_expired = (state_q == HELD) && (cnt_q == CW'(TIMEOUT - 1));
    end else begin : g_no_hold_cnt
      assign hold_expired = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    turn_d  = turn_q;
    terr_d  = 1'b0;
    case (state_q)
      FREE: begin
        if (pick_valid) begin
          grant_d = ONE_LSB << pick_idx;
          busy_d  = 1'b1;
          owner_d = pick_idx;
          state_d = HELD;
        end
      end
      HELD: begin
        if (owner_done || hold_expired) begin
          grant_d = '0;
          busy_d  = 1'b0;
          owner_d = '0;
          turn_d  = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
          terr_d  = ~owner_done;
          state_d = GAP;
        end
      end
      GAP:     state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FREE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      turn_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      turn_q  <= turn_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.turn        = turn_q;
  assign bus.timeout_err = terr_q;

`ifndef SYNTHESIS
  a_mutex : assert property (@(posedge clock) disable iff (reset) $onehot0(grant_q));

  // Grants handed to others while each requester keeps waiting.
  logic [3:0] wait_cnt_q [N];

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset || !bus.req[i]) begin
        wait_cnt_q[i] <= '0;
      end else if (state_q == FREE && pick_valid) begin
        if (pick_idx == IDW'(i)) begin
          wait_cnt_q[i] <= '0;
        end else begin
          a_bounded_wait : assert (wait_cnt_q[i] < 4'(N - 1));
          wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mutex_arbiter.sv
// ============================================================================
// tb_mutex_arbiter : directed self-checking bench, three arbiter configurations
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mutex_arbiter;
  import mutex_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clock = ~clock;

  mutex_arbiter_if #(.N(2)) a_if ();
  mutex_arbiter_if #(.N(4)) b_if ();
  mutex_arbiter_if #(.N(2)) c_if ();

  mutex_arbiter #(.N(2), .TIMEOUT(0)) u_a (.clock(clock), .reset(reset), .bus(a_if));
  mutex_arbiter #(.N(4), .TIMEOUT(0)) u_b (.clock(clock), .reset(reset), .bus(b_if));
  mutex_arbiter #(.N(2), .TIMEOUT(5)) u_c (.clock(clock), .reset(reset), .bus(c_if));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_if.req = '0; a_if.rel = '0;
    b_if.req = '0; b_if.rel = '0;
    c_if.req = '0; c_if.rel = '0;
    tick(); tick();
    tests++; if (a_if.grant !== 2'b00) begin failed++; $display("FAIL reset_grant_a: got %b want 00", a_if.grant); end
    tests++; if (a_if.busy !== 1'b0) begin failed++; $display("FAIL reset_busy_a: got %b want 0", a_if.busy); end
    tests++; if (a_if.owner !== 1'b0) begin failed++; $display("FAIL reset_owner_a: got %0d want 0", a_if.owner); end
    tests++; if (b_if.turn !== 2'd0) begin failed++; $display("FAIL reset_turn_b: got %0d want 0", b_if.turn); end
    tests++; if (c_if.timeout_err !== 1'b0) begin failed++; $display("FAIL reset_terr_c: got %b want 0", c_if.timeout_err); end
    tests++; if (b_if.grant !== 4'b0000) begin failed++; $display("FAIL reset_grant_b: got %b want 0000", b_if.grant); end
    reset = 1'b0;
  endtask

  task automatic test_basic_n2();
    a_if.req = 2'b11;
    tick();
    tests++; if (a_if.grant !== 2'b01) begin failed++; $display("FAIL basic_grant0: got %b want 01", a_if.grant); end
    tests++; if (a_if.busy !== 1'b1 || a_if.owner !== 1'b0) begin failed++; $display("FAIL basic_busy_owner: got busy=%b owner=%0d want 1/0", a_if.busy, a_if.owner); end
    a_if.rel = 2'b01;
    tick();
    a_if.rel = 2'b00;
    tests++; if (a_if.grant !== 2'b00 || a_if.turn !== 1'b1) begin failed++; $display("FAIL basic_gap: got grant=%b turn=%0d want 00/1", a_if.grant, a_if.turn); end
    tick();
    tests++; if (a_if.grant !== 2'b00) begin failed++; $display("FAIL basic_free_idle: got %b want 00", a_if.grant); end
    tick();
    tests++; if (a_if.grant !== 2'b10 || a_if.owner !== 1'b1) begin failed++; $display("FAIL basic_grant1: got grant=%b owner=%0d want 10/1", a_if.grant, a_if.owner); end
    a_if.req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_drop_req();
    a_if.req = 2'b01;
    tick();
    tests++; if (a_if.grant !== 2'b01) begin failed++; $display("FAIL drop_grant0: got %b want 01", a_if.grant); end
    a_if.req = 2'b10;
    tick();
    tests++; if (a_if.grant !== 2'b00 || a_if.turn !== 1'b1 || a_if.timeout_err !== 1'b0) begin
      failed++; $display("FAIL drop_end: got grant=%b turn=%0d terr=%b want 00/1/0", a_if.grant, a_if.turn, a_if.timeout_err);
    end
    tick(); tick();
    tests++; if (a_if.grant !== 2'b10) begin failed++; $display("FAIL drop_next: got %b want 10", a_if.grant); end
    a_if.req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_round_robin_n4();
    logic [3:0] exp;
    int         w;
    b_if.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << (n % 4);
      w = 0;
      while (b_if.grant === 4'b0000 && w < 8) begin
        tick();
        w++;
      end
      tests++; if (b_if.grant !== exp) begin failed++; $display("FAIL rr_order[%0d]: got %b want %b (waited %0d)", n, b_if.grant, exp, w); end
      for (int c = 0; c < 2; c++) begin
        tick();
        tests++; if (!$onehot0(b_if.grant) || b_if.grant !== exp) begin failed++; $display("FAIL rr_hold[%0d]: got %b want %b", n, b_if.grant, exp); end
      end
      b_if.rel = exp;
      tick();
      b_if.rel = 4'b0000;
      tests++; if (b_if.grant !== 4'b0000) begin failed++; $display("FAIL rr_release[%0d]: got %b want 0000", n, b_if.grant); end
    end
    b_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_foreign_release();
    b_if.req = 4'b0001;
    tick();
    tests++; if (b_if.grant !== 4'b0001) begin failed++; $display("FAIL foreign_grant0: got %b want 0001", b_if.grant); end
    b_if.req = 4'b0011;
    b_if.rel = 4'b0010;
    tick();
    b_if.rel = 4'b0000;
    tests++; if (b_if.grant !== 4'b0001) begin failed++; $display("FAIL foreign_ignored: got %b want 0001", b_if.grant); end
    tick(); tick();
    tests++; if (b_if.grant !== 4'b0001) begin failed++; $display("FAIL foreign_still_held: got %b want 0001", b_if.grant); end
    b_if.rel = 4'b0001;
    tick();
    b_if.rel = 4'b0000;
    tests++; if (b_if.grant !== 4'b0000 || b_if.turn !== 2'd1) begin failed++; $display("FAIL foreign_owner_rel: got grant=%b turn=%0d want 0000/1", b_if.grant, b_if.turn); end
    tick(); tick();
    tests++; if (b_if.grant !== 4'b0010) begin failed++; $display("FAIL foreign_next: got %b want 0010", b_if.grant); end
    b_if.req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_timeout();
    c_if.req = 2'b10;
    tick();
    tests++; if (c_if.grant !== 2'b10) begin failed++; $display("FAIL to_grant1: got %b want 10", c_if.grant); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++; if (c_if.grant !== 2'b10 || c_if.timeout_err !== 1'b0) begin
        failed++; $display("FAIL to_hold[%0d]: got grant=%b terr=%b want 10/0", k, c_if.grant, c_if.timeout_err);
      end
    end
    tick();
    c_if.req = 2'b00;
    tests++; if (c_if.grant !== 2'b00 || c_if.timeout_err !== 1'b1 || c_if.turn !== 1'b0) begin
      failed++; $display("FAIL to_revoke: got grant=%b terr=%b turn=%0d want 00/1/0", c_if.grant, c_if.timeout_err, c_if.turn);
    end
    tick();
    tests++; if (c_if.timeout_err !== 1'b0) begin failed++; $display("FAIL to_pulse_once: got %b want 0", c_if.timeout_err); end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    b_if.req = 4'b0100;
    tick();
    tests++; if (b_if.grant !== 4'b0100 || b_if.owner !== 2'd2) begin failed++; $display("FAIL rst_hold_grant2: got grant=%b owner=%0d want 0100/2", b_if.grant, b_if.owner); end
    reset = 1'b1;
    b_if.rel = 4'b0100;
    tick();
    tests++; if (b_if.grant !== 4'b0000 || b_if.turn !== 2'd0 || b_if.busy !== 1'b0) begin
      failed++; $display("FAIL rst_hold_clear: got grant=%b turn=%0d busy=%b want 0000/0/0", b_if.grant, b_if.turn, b_if.busy);
    end
    tests++; if (u_b.state_q !== FREE) begin failed++; $display("FAIL rst_hold_state: got %0d want FREE", u_b.state_q); end
    reset = 1'b0;
    b_if.rel = 4'b0000;
    b_if.req = 4'b1000;
    tick();
    tests++; if (b_if.grant !== 4'b1000 || b_if.owner !== 2'd3) begin failed++; $display("FAIL rst_hold_regrant: got grant=%b owner=%0d want 1000/3", b_if.grant, b_if.owner); end
    b_if.req = 4'b0000;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic_n2();
    test_drop_req();
    test_round_robin_n4();
    test_foreign_release();
    test_timeout();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
